// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, default cycle parameters, retry counter width,
// and a helper used to size the shared cycle counter.
package pll_seq_pkg;

    localparam int RETRY_W = 4;

    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_MAX_RETRIES         = 3;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the PLL lock sequencer and its environment.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level or single-cycle pulses.
//
// Signals: pll_locked (async lock flag), restart (1-cycle request) flow towards
// the sequencer; pll_reset, sys_rst_n, ready, fail, lock_lost, retry_cnt flow
// out of it. The slave modport is the sequencer side.
interface pll_lock_sequencer_if;
    import pll_seq_pkg::*;

    logic               pll_locked;
    logic               restart;
    logic               pll_reset;
    logic               sys_rst_n;
    logic               ready;
    logic               fail;
    logic               lock_lost;
    logic [RETRY_W-1:0] retry_cnt;

    modport master (
        output pll_locked, restart,
        input  pll_reset, sys_rst_n, ready, fail, lock_lost, retry_cnt
    );

    modport slave (
        input  pll_locked, restart,
        output pll_reset, sys_rst_n, ready, fail, lock_lost, retry_cnt
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Latency: 2 clk edges from input change to output change.
// Backpressure: none.
//
// Ports: clk, rst_n (sync active-low, clears both flops), i_d async in, o_q synced out.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, lock qualification and datapath reset release, with retry/fail.
// Latency: outputs registered from next-state; pll_locked acts on the state 2 edges after sampling.
// Backpressure: none; restart is always accepted and overrides every other event.
//
// Ports: clk (100 MHz ref), rst_n (sync active-low), bus (slave modport):
//   pll_locked/restart in; pll_reset, sys_rst_n, ready, fail, lock_lost, retry_cnt out.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pll_lock_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                       LOCK_TIMEOUT_CYCLES)) + 1;

    localparam logic [CNT_W-1:0]   RST_END     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_END  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_END = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    logic               w_locked_s;
    state_t             w_nxt_state;
    logic [RETRY_W-1:0] w_nxt_retry;
    logic               w_nxt_lost;
    logic               w_enter;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pll_reset;
    logic               r_sys_rst_n;
    logic               r_ready;
    logic               r_fail;
    logic               r_lock_lost;
    logic [RETRY_W-1:0] r_retry_cnt;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.pll_locked),
        .o_q   (w_locked_s)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_retry = r_retry_cnt;
        w_nxt_lost  = r_lock_lost;
        if (bus.restart) begin
            // Restart beats lock loss in RUN, so lock_lost is cleared, not set.
            w_nxt_state = PLL_RST;
            w_nxt_retry = '0;
            w_nxt_lost  = 1'b0;
        end else begin
            case (r_state)
                PLL_RST: begin
                    if (r_cnt == RST_END) w_nxt_state = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_nxt_state = STABLE;
                    end else if (r_cnt == TIMEOUT_END) begin
                        if (r_retry_cnt == RETRY_MAX) begin
                            w_nxt_state = FAIL;
                        end else begin
                            w_nxt_state = PLL_RST;
                            w_nxt_retry = r_retry_cnt + RETRY_W'(1);
                        end
                    end
                end
                STABLE: begin
                    // A drop restarts the lock wait without charging a retry.
                    if (!w_locked_s)                w_nxt_state = WAIT_LOCK;
                    else if (r_cnt == STABLE_END)   w_nxt_state = RUN;
                end
                RUN: begin
                    if (!w_locked_s) begin
                        w_nxt_state = PLL_RST;
                        w_nxt_lost  = 1'b1;
                        w_nxt_retry = '0;
                    end
                end
                FAIL:    w_nxt_state = FAIL;
                default: w_nxt_state = PLL_RST;
            endcase
        end
    end

    // Restart re-enters PLL_RST even from PLL_RST, so it also counts as an entry.
    assign w_enter = bus.restart || (w_nxt_state != r_state);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= PLL_RST;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
            r_lock_lost <= 1'b0;
            r_retry_cnt <= '0;
        end else begin
            r_state <= w_nxt_state;
            if (w_enter) begin
                r_cnt <= '0;
            end else if (r_state inside {PLL_RST, WAIT_LOCK, STABLE}) begin
                // RUN/FAIL never use the count; holding it avoids pointless wrap.
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_pll_reset <= (w_nxt_state == PLL_RST) || (w_nxt_state == FAIL);
            r_sys_rst_n <= (w_nxt_state == RUN);
            r_ready     <= (w_nxt_state == RUN);
            r_fail      <= (w_nxt_state == FAIL);
            r_lock_lost <= w_nxt_lost;
            r_retry_cnt <= w_nxt_retry;
        end
    end

    assign bus.pll_reset = r_pll_reset;
    assign bus.sys_rst_n = r_sys_rst_n;
    assign bus.ready     = r_ready;
    assign bus.fail      = r_fail;
    assign bus.lock_lost = r_lock_lost;
    assign bus.retry_cnt = r_retry_cnt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: timed output-change scoreboard plus spot checks.
// Expected output changes (edge number + full output vector) are queued when stimulus is driven.
// A negedge monitor pops one entry per observed output change and compares cycle and value.
module tb_pll_lock_sequencer;
    import pll_seq_pkg::*;

    localparam int P_RST = 4;
    localparam int P_STB = 8;
    localparam int P_TO  = 32;
    localparam int P_RET = 2;

    typedef struct {
        int         cyc;
        logic [8:0] vec;
    } sb_ent_t;

    logic    clk = 1'b0;
    logic    rst_n;
    int      cyc = 0;
    int      n_cmp = 0;
    int      n_err = 0;
    sb_ent_t sb_q[$];

    pll_lock_sequencer_if bus();

    pll_lock_sequencer #(
        .PLL_RST_CYCLES      (P_RST),
        .LOCK_STABLE_CYCLES  (P_STB),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .MAX_RETRIES         (P_RET)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc equals the number of posedges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output vector: {pll_reset, sys_rst_n, ready, fail, lock_lost, retry_cnt}
    function automatic logic [8:0] ov(input logic pr, input logic srn, input logic rdy,
                                      input logic fl, input logic ll, input logic [3:0] rc);
        return {pr, srn, rdy, fl, ll, rc};
    endfunction

    task automatic expect_at(input int c, input logic [8:0] v);
        sb_q.push_back('{c, v});
    endtask

    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    logic [8:0] prev = 'x;

    always @(negedge clk) begin
        logic [8:0] cur;
        sb_ent_t    e;
        cur = {bus.pll_reset, bus.sys_rst_n, bus.ready, bus.fail, bus.lock_lost, bus.retry_cnt};
        if (cur !== prev) begin
            if (sb_q.size() == 0) begin
                check_val($sformatf("sb_unexpected_change out=%h", cur), sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                check_val($sformatf("evt_cyc out=%h", e.vec), cyc, e.cyc);
                check_val($sformatf("evt_out@%0d", e.cyc), {23'd0, cur}, {23'd0, e.vec});
            end
            prev = cur;
        end
    end

    initial begin
        int t;
        rst_n          = 1'b0;
        bus.pll_locked = 1'b0;
        bus.restart    = 1'b0;
        expect_at(1, ov(1, 0, 0, 0, 0, 0));

        // Reset state
        at_cyc(2);
        check_val("rst_pll_reset", bus.pll_reset, 1);
        check_val("rst_sys_rst_n", bus.sys_rst_n, 0);
        check_val("rst_ready", bus.ready, 0);
        check_val("rst_fail", bus.fail, 0);
        check_val("rst_lock_lost", bus.lock_lost, 0);
        check_val("rst_retry_cnt", bus.retry_cnt, 0);

        // Clean lock: last reset edge 3, PLL_RST 4 cycles, lock rises 10 cycles later
        at_cyc(3);
        rst_n = 1'b1;
        expect_at(3 + P_RST, ov(0, 0, 0, 0, 0, 0));
        at_cyc(13);
        bus.pll_locked = 1'b1;
        expect_at(14 + 2 + P_STB, ov(0, 1, 1, 0, 0, 0));
        at_cyc(30);
        check_val("clean_ready", bus.ready, 1);
        check_val("clean_retry", bus.retry_cnt, 0);
        check_val("clean_sb_drained", sb_q.size(), 0);

        // Loss in RUN: sampled at 31, acts at 33; then re-lock keeps lock_lost
        bus.pll_locked = 1'b0;
        expect_at(33, ov(1, 0, 0, 0, 1, 0));
        expect_at(33 + P_RST, ov(0, 0, 0, 0, 1, 0));
        at_cyc(40);
        bus.pll_locked = 1'b1;
        expect_at(41 + 2 + P_STB, ov(0, 1, 1, 0, 1, 0));

        // Reset while in RUN
        at_cyc(55);
        check_val("loss_lock_lost", bus.lock_lost, 1);
        rst_n          = 1'b0;
        bus.pll_locked = 1'b0;
        expect_at(56, ov(1, 0, 0, 0, 0, 0));
        at_cyc(56);
        check_val("rst_run_lock_lost", bus.lock_lost, 0);
        check_val("rst_run_ready", bus.ready, 0);
        at_cyc(57);
        rst_n = 1'b1;
        expect_at(57 + P_RST, ov(0, 0, 0, 0, 0, 0));

        // Glitch in STABLE: STABLE entered at 68, drop in 6th cycle for 3 cycles
        at_cyc(65);
        bus.pll_locked = 1'b1;
        at_cyc(73);
        bus.pll_locked = 1'b0;
        at_cyc(76);
        bus.pll_locked = 1'b1;
        expect_at(77 + 2 + P_STB, ov(0, 1, 1, 0, 0, 0));
        at_cyc(90);
        check_val("glitch_retry", bus.retry_cnt, 0);
        check_val("glitch_sb_drained", sb_q.size(), 0);

        // Reach STABLE again, then reset there
        bus.pll_locked = 1'b0;
        expect_at(93, ov(1, 0, 0, 0, 1, 0));
        expect_at(93 + P_RST, ov(0, 0, 0, 0, 1, 0));
        at_cyc(97);
        bus.pll_locked = 1'b1;
        at_cyc(103);
        rst_n          = 1'b0;
        bus.pll_locked = 1'b0;
        expect_at(104, ov(1, 0, 0, 0, 0, 0));
        at_cyc(104);
        check_val("rst_stable_pll_reset", bus.pll_reset, 1);
        check_val("rst_stable_lock_lost", bus.lock_lost, 0);

        // Never locks: three timeout windows, then FAIL
        at_cyc(105);
        rst_n = 1'b1;
        t = 105 + P_RST;
        expect_at(t, ov(0, 0, 0, 0, 0, 0));
        for (int r = 0; r < P_RET; r++) begin
            t += P_TO;
            expect_at(t, ov(1, 0, 0, 0, 0, 4'(r + 1)));
            t += P_RST;
            expect_at(t, ov(0, 0, 0, 0, 0, 4'(r + 1)));
        end
        t += P_TO;
        expect_at(t, ov(1, 0, 0, 1, 0, 4'(P_RET)));
        at_cyc(259);
        check_val("fail_flag", bus.fail, 1);
        check_val("fail_pll_reset", bus.pll_reset, 1);
        check_val("fail_retry", bus.retry_cnt, P_RET);
        check_val("fail_sb_drained", sb_q.size(), 0);

        // Restart from FAIL
        at_cyc(260);
        bus.restart = 1'b1;
        expect_at(261, ov(1, 0, 0, 0, 0, 0));
        expect_at(261 + P_RST, ov(0, 0, 0, 0, 0, 0));
        at_cyc(261);
        bus.restart = 1'b0;
        check_val("restart_fail_clr", bus.fail, 0);

        // Restart coincident with lock loss in RUN: lock_lost must stay 0
        at_cyc(265);
        bus.pll_locked = 1'b1;
        expect_at(266 + 2 + P_STB, ov(0, 1, 1, 0, 0, 0));
        at_cyc(280);
        bus.pll_locked = 1'b0;
        at_cyc(282);
        bus.restart = 1'b1;
        expect_at(283, ov(1, 0, 0, 0, 0, 0));
        expect_at(283 + P_RST, ov(0, 0, 0, 0, 0, 0));
        at_cyc(283);
        bus.restart = 1'b0;
        check_val("restart_loss_lock_lost", bus.lock_lost, 0);
        check_val("restart_loss_pll_reset", bus.pll_reset, 1);

        at_cyc(300);
        check_val("final_sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
